// File: rtl/cap_acptx_sched_pkg.sv
// rtl/cap_acptx_sched_pkg.sv - shared types and helpers for the capture-to-ACP TX scheduler
package cap_acptx_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } sched_state_t;

    localparam int MAX_NCH    = 8;
    localparam int MAX_ADDR_W = 64;

    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int blk_shift(input int blk_bytes);
        return $clog2(blk_bytes);
    endfunction

    // Extracts channel ch's base from a zero-extended packed base bus.
    function automatic logic [MAX_ADDR_W-1:0] base_slice(
        input logic [MAX_NCH*MAX_ADDR_W-1:0] bases,
        input int                            ch,
        input int                            addr_w
    );
        logic [MAX_NCH*MAX_ADDR_W-1:0] sh;
        logic [MAX_ADDR_W-1:0]         mask;
        sh   = bases >> (ch * addr_w);
        mask = (addr_w >= MAX_ADDR_W) ? '1 : ((MAX_ADDR_W'(1) << addr_w) - MAX_ADDR_W'(1));
        return sh[MAX_ADDR_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/cap_rr_arb.sv
// rtl/cap_rr_arb.sv - combinational round-robin picker: first requester at or after ptr
module cap_rr_arb #(
    parameter int NCH  = 4,
    parameter int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [CH_W-1:0] gnt_idx
);

    logic [CH_W-1:0] ci;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        ci      = '0;
        for (int off = NCH - 1; off >= 0; off--) begin
            ci = CH_W'((int'(ptr) + off) % NCH);
            if (req[ci]) begin
                gnt     = '0;
                gnt[ci] = 1'b1;
                gnt_idx = ci;
            end
        end
    end

endmodule

// File: rtl/cap_acptx_sched.sv
// rtl/cap_acptx_sched.sv - round-robin scheduler of capture blocks onto one ACP TX engine
module cap_acptx_sched
    import cap_acptx_sched_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int ADDR_W    = 32,
    parameter int CRC_W     = 32,
    parameter int BLK_BYTES = 4096,
    parameter int IDX_W     = 16,
    parameter int TIMEOUT   = 1048576
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sched_en,
    input  logic                     soft_clr,
    input  logic [NCH*ADDR_W-1:0]    cfg_base,
    input  logic [IDX_W-1:0]         cfg_blocks,
    input  logic [NCH-1:0]           ch_req,
    output logic [$clog2(NCH)-1:0]   ch_sel,
    output logic                     tacp_en,
    input  logic                     tacp_cmpt,
    output logic [ADDR_W-1:0]        cap_addr,
    input  logic [CRC_W-1:0]         cap_crc32,
    output logic                     done_vld,
    output logic [$clog2(NCH)-1:0]   done_ch,
    output logic [IDX_W-1:0]         done_idx,
    output logic [CRC_W-1:0]         done_crc,
    output logic                     busy,
    output logic [NCH-1:0]           err_to
);

    localparam int CH_W      = ch_width(NCH);
    localparam int BLK_SHIFT = blk_shift(BLK_BYTES);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);
    localparam logic [31:0]     WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    sched_state_t      state;
    logic [CH_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]  idx [NCH];
    logic [31:0]       wd_cnt;
    logic              clr_pend;

    logic [NCH-1:0]    gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [MAX_NCH*MAX_ADDR_W-1:0] base_bus;
    logic [ADDR_W-1:0] grant_addr;
    logic [IDX_W-1:0]  blk_last;
    logic [IDX_W-1:0]  idx_next;
    logic [CH_W-1:0]   ptr_next;
    logic              wd_hit;
    logic              xfer_end;
    logic              do_clr;

    cap_rr_arb #(.NCH(NCH), .CH_W(CH_W)) u_arb (
        .req     (ch_req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign gnt_any    = |gnt;
    assign base_bus   = (MAX_NCH*MAX_ADDR_W)'(cfg_base);
    assign grant_addr = ADDR_W'(base_slice(base_bus, int'(gnt_idx), ADDR_W))
                      + (ADDR_W'(idx[gnt_idx]) << BLK_SHIFT);
    // A ring of 0 blocks behaves as a ring of 1.
    assign blk_last   = (cfg_blocks == '0) ? '0 : cfg_blocks - IDX_W'(1);
    assign idx_next   = (idx[ch_sel] >= blk_last) ? '0 : idx[ch_sel] + IDX_W'(1);
    assign ptr_next   = (ch_sel == LAST_CH) ? '0 : ch_sel + CH_W'(1);
    assign wd_hit     = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
    assign xfer_end   = (state == S_WAIT) && (tacp_cmpt || wd_hit);
    // A clear seen during a transfer is held back until that transfer ends.
    assign do_clr     = (state != S_WAIT) ? soft_clr : (xfer_end && (clr_pend || soft_clr));
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            for (int i = 0; i < NCH; i++) idx[i] <= '0;
            ch_sel   <= '0;
            cap_addr <= '0;
            tacp_en  <= 1'b0;
            done_vld <= 1'b0;
            done_ch  <= '0;
            done_idx <= '0;
            done_crc <= '0;
            err_to   <= '0;
            wd_cnt   <= '0;
            clr_pend <= 1'b0;
        end else begin
            done_vld <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    // Granting straight from DONE keeps the enable gap to one cycle.
                    if (!soft_clr && sched_en && gnt_any) begin
                        ch_sel   <= gnt_idx;
                        cap_addr <= grant_addr;
                        tacp_en  <= 1'b1;
                        wd_cnt   <= '0;
                        state    <= S_WAIT;
                    end else begin
                        state    <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    wd_cnt <= wd_cnt + 32'd1;
                    if (soft_clr) clr_pend <= 1'b1;
                    if (tacp_cmpt) begin
                        tacp_en      <= 1'b0;
                        done_vld     <= 1'b1;
                        done_ch      <= ch_sel;
                        done_idx     <= idx[ch_sel];
                        done_crc     <= cap_crc32;
                        idx[ch_sel]  <= idx_next;
                        rr_ptr       <= ptr_next;
                        state        <= S_DONE;
                    end else if (wd_hit) begin
                        tacp_en        <= 1'b0;
                        err_to[ch_sel] <= 1'b1;
                        rr_ptr         <= ptr_next;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (do_clr) begin
                for (int i = 0; i < NCH; i++) idx[i] <= '0;
                rr_ptr   <= '0;
                err_to   <= '0;
                clr_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cap_acptx_sched.sv
// tb/tb_cap_acptx_sched.sv - directed self-checking bench for cap_acptx_sched
module tb_cap_acptx_sched;

    logic         clk;
    logic         rst;
    logic         sched_en;
    logic         soft_clr;
    logic [127:0] cfg_base;
    logic [15:0]  cfg_blocks;
    logic [3:0]   ch_req;
    logic [1:0]   ch_sel;
    logic         tacp_en;
    logic         tacp_cmpt;
    logic [31:0]  cap_addr;
    logic [31:0]  cap_crc32;
    logic         done_vld;
    logic [1:0]   done_ch;
    logic [15:0]  done_idx;
    logic [31:0]  done_crc;
    logic         busy;
    logic [3:0]   err_to;

    int total = 0;
    int bad   = 0;

    cap_acptx_sched #(
        .NCH(4), .ADDR_W(32), .CRC_W(32), .BLK_BYTES(4096), .IDX_W(16), .TIMEOUT(100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sched_en   (sched_en),
        .soft_clr   (soft_clr),
        .cfg_base   (cfg_base),
        .cfg_blocks (cfg_blocks),
        .ch_req     (ch_req),
        .ch_sel     (ch_sel),
        .tacp_en    (tacp_en),
        .tacp_cmpt  (tacp_cmpt),
        .cap_addr   (cap_addr),
        .cap_crc32  (cap_crc32),
        .done_vld   (done_vld),
        .done_ch    (done_ch),
        .done_idx   (done_idx),
        .done_crc   (done_crc),
        .busy       (busy),
        .err_to     (err_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] base_of(input int ch);
        return (32'(ch) + 32'd1) << 28;
    endfunction

    // Waits for a grant, checks it, runs dly WAIT cycles, completes, checks the done pulse.
    task automatic run_block(input int ch, input logic [31:0] addr, input int idx,
                             input logic [31:0] crc, input int dly,
                             input logic [3:0] req_after, input logic en_after,
                             input logic clr_mid);
        int n;
        n = 0;
        while (!tacp_en && n < 20) begin
            tick;
            n++;
        end
        chk("grant_en", tacp_en, 1);
        chk("grant_ch", ch_sel, ch);
        chk("grant_addr", cap_addr, addr);
        ch_req   = req_after;
        sched_en = en_after;
        for (int i = 0; i < dly; i++) begin
            soft_clr = clr_mid && (i == 0);
            tick;
        end
        soft_clr = 1'b0;
        chk("hold_en", tacp_en, 1);
        chk("hold_addr", cap_addr, addr);
        tacp_cmpt = 1'b1;
        cap_crc32 = crc;
        tick;
        tacp_cmpt = 1'b0;
        cap_crc32 = '0;
        chk("done_vld", done_vld, 1);
        chk("done_ch", done_ch, ch);
        chk("done_idx", done_idx, idx);
        chk("done_crc", done_crc, crc);
        chk("en_low", tacp_en, 0);
    endtask

    initial begin
        int n;
        int cnt;
        logic seen;

        rst        = 1'b1;
        sched_en   = 1'b0;
        soft_clr   = 1'b0;
        tacp_cmpt  = 1'b0;
        cap_crc32  = '0;
        ch_req     = '0;
        cfg_blocks = 16'd2;
        cfg_base   = {base_of(3), base_of(2), base_of(1), base_of(0)};
        repeat (3) tick;
        chk("rst_en", tacp_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_vld, 0);
        chk("rst_err", err_to, 0);
        chk("rst_addr", cap_addr, 0);
        chk("rst_sel", ch_sel, 0);
        chk("rst_dcrc", done_crc, 0);
        rst = 1'b0;
        tick;

        // single channel, ring of 2 wraps
        ch_req   = 4'b0001;
        sched_en = 1'b1;
        tick;
        chk("latency", tacp_en, 1);
        run_block(0, 32'h1000_0000, 0, 32'hDEAD_BEEF, 50, 4'b0001, 1'b1, 1'b0);
        run_block(0, 32'h1000_1000, 1, 32'hDEAD_BEEF, 50, 4'b0001, 1'b1, 1'b0);
        run_block(0, 32'h1000_0000, 0, 32'hDEAD_BEEF, 50, 4'b0000, 1'b1, 1'b0);
        tick;
        chk("idle_busy", busy, 0);
        soft_clr = 1'b1;
        tick;
        soft_clr = 1'b0;

        // all channels requesting: strict rotation with a one-cycle enable gap
        ch_req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            run_block(k % 4, base_of(k % 4) + ((k == 4) ? 32'h1000 : 32'h0), (k == 4) ? 1 : 0,
                      32'hA000_0000 + 32'(k), 5 + k, (k == 4) ? 4'h0 : 4'hF, 1'b1, 1'b0);
            if (k < 4) begin
                tick;
                chk("gap", tacp_en, 1);
            end
        end

        // watchdog on ch2
        ch_req = 4'b0100;
        n = 0;
        while (!tacp_en && n < 20) begin
            tick;
            n++;
        end
        chk("wd_grant", ch_sel, 2);
        chk("wd_addr", cap_addr, 32'h3000_1000);
        ch_req = 4'b1100;
        cnt  = 0;
        seen = 1'b0;
        while (tacp_en && cnt < 200) begin
            cnt++;
            if (done_vld) seen = 1'b1;
            tick;
        end
        chk("wd_cycles", cnt, 100);
        chk("wd_err", err_to, 4'b0100);
        chk("wd_nodone", seen | done_vld, 0);
        chk("wd_idle", busy, 0);
        run_block(3, 32'h4000_1000, 1, 32'h1234_5678, 10, 4'b0100, 1'b1, 1'b0);
        run_block(2, 32'h3000_1000, 1, 32'hCAFE_F00D, 10, 4'b0000, 1'b1, 1'b0);
        tick;
        soft_clr = 1'b1;
        tick;
        soft_clr = 1'b0;
        chk("clr_err", err_to, 0);

        // completion in the last watchdog cycle wins
        ch_req = 4'b0010;
        run_block(1, 32'h2000_0000, 0, 32'h0BAD_F00D, 99, 4'b0000, 1'b1, 1'b0);
        chk("late_err", err_to, 0);

        // sched_en dropped mid-transfer
        ch_req = 4'b0001;
        run_block(0, 32'h1000_0000, 0, 32'h5555_AAAA, 20, 4'b0001, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (tacp_en) seen = 1'b1;
        end
        chk("no_regrant", seen, 0);

        // soft_clr mid-transfer overrides the index advance
        cfg_blocks = 16'd4;
        sched_en   = 1'b1;
        run_block(0, 32'h1000_1000, 1, 32'h0101_0101, 20, 4'b0011, 1'b1, 1'b1);
        run_block(0, 32'h1000_0000, 0, 32'h0202_0202, 5, 4'b0010, 1'b1, 1'b0);
        run_block(1, 32'h2000_0000, 0, 32'h0303_0303, 5, 4'b0000, 1'b1, 1'b0);
        tick;

        // asynchronous reset mid-transfer
        ch_req = 4'b0100;
        n = 0;
        while (!tacp_en && n < 20) begin
            tick;
            n++;
        end
        chk("pre_rst_ch", ch_sel, 2);
        repeat (5) tick;
        rst = 1'b1;
        #1;
        chk("arst_en", tacp_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done_vld, 0);
        ch_req = 4'b0101;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_block(0, 32'h1000_0000, 0, 32'h7777_7777, 5, 4'b0000, 1'b1, 1'b0);
        repeat (3) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cap_acptx_sched.md
Name: cap_acptx_sched

Overview:
- Schedules capture-block transfers from NCH capture channels onto a single capture-to-ACP TX engine. That engine has an enable/complete handshake, a start address input and a CRC32 result output.
- Arbitrates round-robin and drives the engine's enable and address from per-channel ring-buffer indices.
- Captures the CRC of each finished block and reports completions. Detects engine hangs with a watchdog.

Parameters:
NCH, 4, number of capture channels (2..8)
ADDR_W, 32, DDR address width
CRC_W, 32, CRC width
BLK_BYTES, 4096, bytes per block; power of two
IDX_W, 16, ring index width
TIMEOUT, 1048576, watchdog cycles in WAIT; 0 disables it

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
sched_en  in  1  allow new grants
soft_clr  in  1  1-cycle pulse; zeroes ring indices, pointer and sticky errors
cfg_base  in  NCH*ADDR_W  per-channel ring base address; channel i uses bits [i*ADDR_W +: ADDR_W]
cfg_blocks  in  IDX_W  blocks per ring, common to all channels; 0 is treated as 1
ch_req  in  NCH  level; channel has a full block buffered
ch_sel  out  $clog2(NCH)  granted channel; used to mux buff_* to the engine
tacp_en  out  1  engine start; held until complete
tacp_cmpt  in  1  engine complete pulse
cap_addr  out  ADDR_W  block start address
cap_crc32  in  CRC_W  engine CRC; valid in the tacp_cmpt cycle
done_vld  out  1  1-cycle completion pulse
done_ch  out  $clog2(NCH)  channel that completed
done_idx  out  IDX_W  ring index written
done_crc  out  CRC_W  CRC of the block
busy  out  1  state is not IDLE
err_to  out  NCH  sticky per-channel timeout flags

Behaviour:
- Reset values: all outputs 0. State IDLE, RR pointer 0, all ring indices 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE, when sched_en=1 and ch_req is nonzero:
  - Pick the first requesting channel at or after the RR pointer, wrapping modulo NCH.
  - Next cycle: register ch_sel and cap_addr, where cap_addr = base[ch] + idx[ch]*BLK_BYTES (modulo 2^ADDR_W). Assert tacp_en and enter WAIT.
  - Latency from request sampled to tacp_en high is 1 cycle.
- WAIT:
  - tacp_en, ch_sel and cap_addr stay stable.
  - tacp_cmpt=1 at cycle M: latch cap_crc32. At M+1: tacp_en=0, done_vld=1 with done_ch, done_idx = old index and done_crc. Go to DONE.
- DONE: lasts 1 cycle, then IDLE. This gives the engine a cycle of tacp_en low between blocks.
- At the done_vld cycle:
  - Index advance: idx[ch] becomes 0 if idx[ch] >= cfg_blocks-1, otherwise idx[ch]+1.
  - RR pointer becomes ch+1 modulo NCH.
- Watchdog (TIMEOUT != 0):
  - Counter clears on WAIT entry and counts every WAIT cycle.
  - At count TIMEOUT-1 without tacp_cmpt: set err_to[ch], drop tacp_en, go to IDLE.
  - No done_vld; index not advanced; RR pointer advanced.
  - If tacp_cmpt arrives in the same cycle, completion wins and there is no error.
- tacp_cmpt outside WAIT is ignored.
- sched_en deasserted during WAIT: the current transfer completes normally; no new grant follows.
- soft_clr:
  - In IDLE or DONE: takes effect the next cycle.
  - During WAIT: deferred until the transfer ends. The completing block's index advance is overridden by the clear.
- ch_req deasserting during WAIT has no effect.
- cfg_base and cfg_blocks are sampled only at grant or index advance. Software changes them only while busy=0.
- Asynchronous rst mid-transfer: tacp_en drops immediately. The engine is reset by the same rst.

Decomposition:
- Shared package: state encoding, CH_W = $clog2(NCH), BLK_SHIFT = $clog2(BLK_BYTES), cfg_base slice helper.
- Sub-module cap_rr_arb: combinational round-robin picker.
  - Inputs: req and pointer.
  - Outputs: one-hot grant and index.
  - Parameterised by NCH and reused by other schedulers.

Test Plan:
- Single channel: ch_req=4'b0001, base0=0x1000_0000, cfg_blocks=2, cmpt after 50 cycles with CRC 0xDEADBEEF, three times -> cap_addr 0x1000_0000, 0x1000_1000, 0x1000_0000 (wrap); done_crc=0xDEADBEEF; done_idx 0,1,0.
- All four ch_req held high -> grant order 0,1,2,3,0; tacp_en low for exactly 1 cycle between blocks.
- TIMEOUT=100 with tacp_cmpt never asserted on ch2 -> tacp_en drops after 100 WAIT cycles; err_to=4'b0100; no done_vld; next grant is ch3; idx2 unchanged.
- tacp_cmpt in the final watchdog cycle -> done_vld=1 and err_to=0.
- sched_en dropped mid-WAIT -> that transfer's done_vld fires; no further tacp_en while ch_req stays high. soft_clr mid-WAIT -> all indices 0 after completion.
- rst asserted mid-WAIT -> tacp_en, busy and done_vld all 0 in the same cycle. After release, the first grant goes to ch0 at base0.
